// File: rtl/adbg_biu_burst_ctrl.sv
// Debug-side BIU burst initiator: splits one burst command into single
// strobe/ready BIU accesses, fed and drained by valid/ready data streams.
module adbg_biu_burst_ctrl #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int CNT_WIDTH    = 16,
  parameter int ABORT_ON_ERR = 0
) (
  input  logic                  biu_clk,
  input  logic                  biu_rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic                  cmd_write,
  input  logic [3:0]            cmd_word_size,
  input  logic [CNT_WIDTH-1:0]  cmd_count,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  biu_strb,
  output logic                  biu_rw,
  output logic [ADDR_WIDTH-1:0] biu_addr,
  output logic [DATA_WIDTH-1:0] biu_di,
  output logic [3:0]            biu_word_size,
  input  logic                  biu_rdy,
  input  logic [DATA_WIDTH-1:0] biu_do,
  input  logic                  biu_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WDATA,
    S_STROBE,
    S_WAIT,
    S_RDATA,
    S_DONE
  } state_t;

  state_t                r_state;
  state_t                w_nxt;
  logic                  r_cmd_rdy;
  logic                  r_strb;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_write;
  logic [3:0]            r_size;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic [DATA_WIDTH-1:0] r_di;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_err;

  logic                  w_accept;
  logic                  w_size_ok;
  logic [CNT_WIDTH-1:0]  w_cnt_dec;
  logic                  w_more_wait;
  logic                  w_more_rd;
  logic                  w_err_n;
  logic                  w_abort_wait;
  logic                  w_abort_rd;
  logic [6:0]            w_shamt;
  logic [DATA_WIDTH-1:0] w_lane;

  assign w_accept     = cmd_valid && r_cmd_rdy;
  assign w_cnt_dec    = r_cnt - CNT_WIDTH'(1);
  assign w_more_wait  = (w_cnt_dec != '0);
  assign w_more_rd    = (r_cnt != '0);
  assign w_err_n      = r_err | biu_err;
  assign w_abort_wait = (ABORT_ON_ERR != 0) && w_err_n;
  assign w_abort_rd   = (ABORT_ON_ERR != 0) && r_err;

  // BIU expects narrow write data in the top lanes of biu_di
  assign w_shamt = 7'(DATA_WIDTH) - {r_size, 3'b000};
  assign w_lane  = wr_data << w_shamt;

  always_comb begin
    w_size_ok = 1'b0;
    unique case (cmd_word_size)
      4'd1, 4'd2, 4'd4: w_size_ok = 1'b1;
      4'd8:             w_size_ok = (DATA_WIDTH == 64);
      default:          w_size_ok = 1'b0;
    endcase
  end

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (cmd_count == '0)   w_nxt = S_DONE;
          else if (!w_size_ok)   w_nxt = S_DONE;
          else if (cmd_write)    w_nxt = S_WDATA;
          else                   w_nxt = S_STROBE;
        end
      end
      S_WDATA: begin
        if (wr_valid) w_nxt = S_STROBE;
      end
      S_STROBE: begin
        if (biu_rdy) w_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (biu_rdy) begin
          if (!r_write)
            w_nxt = S_RDATA;
          else if (w_more_wait && !w_abort_wait)
            w_nxt = S_WDATA;
          else
            w_nxt = S_DONE;
        end
      end
      S_RDATA: begin
        if (rd_ready) begin
          if (w_more_rd && !w_abort_rd) w_nxt = S_STROBE;
          else                          w_nxt = S_DONE;
        end
      end
      S_DONE:  w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge biu_clk or posedge biu_rst) begin
    if (biu_rst) begin
      r_state   <= S_IDLE;
      r_cmd_rdy <= 1'b0;
      r_strb    <= 1'b0;
      r_addr    <= '0;
      r_write   <= 1'b0;
      r_size    <= '0;
      r_cnt     <= '0;
      r_di      <= '0;
      r_rdata   <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_nxt;
      r_cmd_rdy <= (w_nxt == S_IDLE);
      r_strb    <= (w_nxt == S_STROBE);
      if (w_accept) begin
        r_addr  <= cmd_addr;
        r_write <= cmd_write;
        r_size  <= cmd_word_size;
        r_cnt   <= cmd_count;
        r_err   <= (cmd_count != '0) && !w_size_ok;
      end
      if (r_state == S_WDATA && wr_valid) begin
        r_di <= w_lane;
      end
      if (r_state == S_WAIT && biu_rdy) begin
        r_err  <= w_err_n;
        r_cnt  <= w_cnt_dec;
        r_addr <= r_addr + ADDR_WIDTH'(r_size);
        if (!r_write) r_rdata <= biu_do;
      end
    end
  end

  assign cmd_ready     = r_cmd_rdy;
  assign wr_ready      = (r_state == S_WDATA);
  assign rd_valid      = (r_state == S_RDATA);
  assign rd_data       = r_rdata;
  assign busy          = (r_state != S_IDLE);
  assign done          = (r_state == S_DONE);
  assign err           = r_err;
  assign biu_strb      = r_strb;
  assign biu_rw        = !r_write;
  assign biu_addr      = r_addr;
  assign biu_di        = r_di;
  assign biu_word_size = r_size;

endmodule

// File: tb/tb_adbg_biu_burst_ctrl.sv
// Directed bench for adbg_biu_burst_ctrl: two instances (no-abort and
// abort-on-error) share stimulus, each with its own BIU responder model.
module tb_adbg_biu_burst_ctrl;

  logic        biu_clk = 1'b0;
  logic        biu_rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic        cmd_write = 1'b0;
  logic [3:0]  cmd_word_size = '0;
  logic [15:0] cmd_count = '0;
  logic        wr_valid = 1'b0;
  logic [31:0] wr_data = '0;
  logic        rd_ready = 1'b1;

  int err_at = 0;
  int n_chk = 0;
  int n_err = 0;
  int s_st[2];
  int s_rd[2];
  int s_dn[2];

  always #5 biu_clk = ~biu_clk;

  for (genvar gi = 0; gi < 2; gi++) begin : g_m
    logic        cmd_ready, wr_ready, rd_valid, busy, done, err;
    logic        strb, rw, biu_rdy, biu_err;
    logic [31:0] rd_data, addr, di, biu_do;
    logic [3:0]  wsz;
    int          n_strb = 0, n_rd = 0, n_done = 0;
    int          lat = 0, k = 0, kc = 0;
    logic        last_err = 1'b0;
    logic [31:0] la [256];
    logic [31:0] ld [256];
    logic [31:0] lrd [256];
    logic        lrw [256];
    logic [3:0]  lsz [256];

    adbg_biu_burst_ctrl #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32),
      .CNT_WIDTH(16), .ABORT_ON_ERR(gi)
    ) u_dut (
      .biu_clk(biu_clk), .biu_rst(biu_rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_addr(cmd_addr), .cmd_write(cmd_write),
      .cmd_word_size(cmd_word_size), .cmd_count(cmd_count),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
      .busy(busy), .done(done), .err(err),
      .biu_strb(strb), .biu_rw(rw), .biu_addr(addr),
      .biu_di(di), .biu_word_size(wsz),
      .biu_rdy(biu_rdy), .biu_do(biu_do), .biu_err(biu_err)
    );

    // BIU responder: 3-cycle access, data 0x1111*(n) for nth access
    always @(posedge biu_clk or posedge biu_rst) begin
      if (biu_rst) begin
        biu_rdy <= 1'b1;
        biu_err <= 1'b0;
        biu_do  <= '0;
        lat     <= 0;
        k       <= 0;
        kc      <= 0;
      end else if (cmd_valid && cmd_ready) begin
        kc <= 0;
      end else if (strb && biu_rdy) begin
        biu_rdy <= 1'b0;
        biu_err <= 1'b0;
        lat     <= 2;
        k       <= kc;
        kc      <= kc + 1;
      end else if (!biu_rdy) begin
        if (lat == 0) begin
          biu_rdy <= 1'b1;
          biu_do  <= 32'(32'h1111 * (k + 1));
          biu_err <= ((k + 1) == err_at);
        end else begin
          lat <= lat - 1;
        end
      end
    end

    always @(posedge biu_clk) begin
      if (strb && biu_rdy) begin
        la[n_strb % 256]  <= addr;
        ld[n_strb % 256]  <= di;
        lrw[n_strb % 256] <= rw;
        lsz[n_strb % 256] <= wsz;
        n_strb <= n_strb + 1;
      end
      if (rd_valid && rd_ready) begin
        lrd[n_rd % 256] <= rd_data;
        n_rd <= n_rd + 1;
      end
      if (done) begin
        n_done   <= n_done + 1;
        last_err <= err;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int ix(input int b, input int o);
    return (b + o) % 256;
  endfunction

  task automatic snap();
    s_st[0] = g_m[0].n_strb;
    s_st[1] = g_m[1].n_strb;
    s_rd[0] = g_m[0].n_rd;
    s_rd[1] = g_m[1].n_rd;
    s_dn[0] = g_m[0].n_done;
    s_dn[1] = g_m[1].n_done;
  endtask

  task automatic send_cmd(input logic [31:0] a, input logic w,
                          input logic [3:0] sz, input logic [15:0] c);
    int t = 0;
    @(negedge biu_clk);
    cmd_addr = a;
    cmd_write = w;
    cmd_word_size = sz;
    cmd_count = c;
    cmd_valid = 1'b1;
    while (!g_m[0].cmd_ready && t < 50) begin
      @(negedge biu_clk);
      t++;
    end
    chk("cmd_ready", g_m[0].cmd_ready, 1);
    @(posedge biu_clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic send_wr(input logic [31:0] d);
    int t = 0;
    @(negedge biu_clk);
    wr_data = d;
    wr_valid = 1'b1;
    while (!g_m[0].wr_ready && t < 50) begin
      @(negedge biu_clk);
      t++;
    end
    chk("wr_ready", g_m[0].wr_ready, 1);
    @(posedge biu_clk);
    #1 wr_valid = 1'b0;
    chk("wr_strb_lat", g_m[0].strb, 1);
  endtask

  task automatic wait_done();
    int t = 0;
    while (!(g_m[0].n_done > s_dn[0] && g_m[1].n_done > s_dn[1])
           && t < 300) begin
      @(negedge biu_clk);
      t++;
    end
    chk("done_seen", t < 300, 1);
  endtask

  initial begin
    logic [31:0] v;
    int t;

    @(negedge biu_clk);
    chk("rst_rw", g_m[0].rw, 1);
    chk("rst_flags", {g_m[0].cmd_ready, g_m[0].busy, g_m[0].done,
        g_m[0].err, g_m[0].strb, g_m[0].wr_ready, g_m[0].rd_valid}, 0);
    chk("rst_addr", g_m[0].addr, 0);
    chk("rst_wsz", g_m[0].wsz, 0);
    chk("rst_rdata", g_m[0].rd_data, 0);
    biu_rst = 1'b0;
    repeat (2) @(negedge biu_clk);
    chk("idle_ready", g_m[0].cmd_ready, 1);

    // single word write
    snap();
    send_cmd(32'h1000, 1'b1, 4'd4, 16'd1);
    chk("w1_busy", g_m[0].busy, 1);
    send_wr(32'hDEADBEEF);
    wait_done();
    chk("w1_nstrb", g_m[0].n_strb - s_st[0], 1);
    chk("w1_addr", g_m[0].la[ix(s_st[0], 0)], 32'h1000);
    chk("w1_rw", g_m[0].lrw[ix(s_st[0], 0)], 0);
    chk("w1_di", g_m[0].ld[ix(s_st[0], 0)], 32'hDEADBEEF);
    chk("w1_sz", g_m[0].lsz[ix(s_st[0], 0)], 4);
    chk("w1_err", g_m[0].last_err, 0);

    // halfword read burst
    snap();
    send_cmd(32'h2000, 1'b0, 4'd2, 16'd3);
    chk("r3_strb_lat", g_m[0].strb, 1);
    wait_done();
    chk("r3_nstrb", g_m[0].n_strb - s_st[0], 3);
    chk("r3_nrd", g_m[0].n_rd - s_rd[0], 3);
    for (int i = 0; i < 3; i++) begin
      chk("r3_addr", g_m[0].la[ix(s_st[0], i)], 32'h2000 + 2 * i);
      chk("r3_rw", g_m[0].lrw[ix(s_st[0], i)], 1);
      chk("r3_sz", g_m[0].lsz[ix(s_st[0], i)], 2);
      chk("r3_data", g_m[0].lrd[ix(s_rd[0], i)], 32'h1111 * (i + 1));
    end
    chk("r3_err", g_m[0].last_err, 0);

    // byte lanes and address wrap
    snap();
    send_cmd(32'hFFFFFFFF, 1'b1, 4'd1, 16'd2);
    send_wr(32'h000000A5);
    send_wr(32'h0000005A);
    wait_done();
    chk("wb_nstrb", g_m[0].n_strb - s_st[0], 2);
    chk("wb_addr0", g_m[0].la[ix(s_st[0], 0)], 32'hFFFFFFFF);
    chk("wb_addr1", g_m[0].la[ix(s_st[0], 1)], 32'h00000000);
    chk("wb_di0", g_m[0].ld[ix(s_st[0], 0)], 32'hA5000000);
    chk("wb_di1", g_m[0].ld[ix(s_st[0], 1)], 32'h5A000000);

    // halfword lane
    snap();
    send_cmd(32'h10, 1'b1, 4'd2, 16'd1);
    send_wr(32'h1234ABCD);
    wait_done();
    chk("wh_di", g_m[0].ld[ix(s_st[0], 0)], 32'hABCD0000);

    // error on the second access
    err_at = 2;
    snap();
    send_cmd(32'h4000, 1'b0, 4'd4, 16'd4);
    wait_done();
    chk("e0_nstrb", g_m[0].n_strb - s_st[0], 4);
    chk("e0_nrd", g_m[0].n_rd - s_rd[0], 4);
    chk("e0_err", g_m[0].last_err, 1);
    chk("e0_err_held", g_m[0].err, 1);
    chk("e1_nstrb", g_m[1].n_strb - s_st[1], 2);
    chk("e1_nrd", g_m[1].n_rd - s_rd[1], 2);
    chk("e1_err", g_m[1].last_err, 1);
    err_at = 0;

    // read backpressure
    rd_ready = 1'b0;
    snap();
    send_cmd(32'h3000, 1'b0, 4'd4, 16'd2);
    chk("bp_err_clr", g_m[0].err, 0);
    t = 0;
    while (!g_m[0].rd_valid && t < 50) begin
      @(negedge biu_clk);
      t++;
    end
    chk("bp_rvalid", g_m[0].rd_valid, 1);
    repeat (10) @(negedge biu_clk);
    v = g_m[0].rd_data;
    chk("bp_nstrb", g_m[0].n_strb - s_st[0], 1);
    chk("bp_rdata", v, 32'h1111);
    chk("bp_rvalid_hold", g_m[0].rd_valid, 1);
    chk("bp_wsz", g_m[0].wsz, 4);
    rd_ready = 1'b1;
    wait_done();
    chk("bp_nstrb_end", g_m[0].n_strb - s_st[0], 2);
    chk("bp_data1", g_m[0].lrd[ix(s_rd[0], 1)], 32'h2222);
    chk("bp_addr1", g_m[0].la[ix(s_st[0], 1)], 32'h3004);

    // zero count
    snap();
    send_cmd(32'h5000, 1'b0, 4'd4, 16'd0);
    wait_done();
    chk("z_nstrb", g_m[0].n_strb - s_st[0], 0);
    chk("z_err", g_m[0].last_err, 0);

    // illegal size
    snap();
    send_cmd(32'h5000, 1'b0, 4'd3, 16'd1);
    wait_done();
    chk("s3_nstrb", g_m[0].n_strb - s_st[0], 0);
    chk("s3_err", g_m[0].last_err, 1);

    // reset while waiting on the BIU
    snap();
    send_cmd(32'h6000, 1'b0, 4'd4, 16'd2);
    @(negedge biu_clk);
    @(negedge biu_clk);
    chk("wr_state", {g_m[0].busy, g_m[0].strb, g_m[0].biu_rdy}, 3'b100);
    biu_rst = 1'b1;
    #1;
    chk("ar_flags", {g_m[0].cmd_ready, g_m[0].busy, g_m[0].done,
        g_m[0].strb, g_m[0].rd_valid}, 0);
    chk("ar_rw", g_m[0].rw, 1);
    chk("ar_addr", g_m[0].addr, 0);
    repeat (2) @(negedge biu_clk);
    biu_rst = 1'b0;
    repeat (3) @(negedge biu_clk);
    chk("ar_no_done", g_m[0].n_done - s_dn[0], 0);

    snap();
    send_cmd(32'h7000, 1'b0, 4'd4, 16'd1);
    chk("ar_strb_lat", g_m[0].strb, 1);
    wait_done();
    chk("ar_nrd", g_m[0].n_rd - s_rd[0], 1);
    chk("ar_data", g_m[0].lrd[ix(s_rd[0], 0)], 32'h1111);
    chk("ar_addr2", g_m[0].la[ix(s_st[0], 0)], 32'h7000);
    chk("ar_err", g_m[0].last_err, 0);

    repeat (3) @(negedge biu_clk);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
